// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared definitions for the multi-cycle control sequencer.
//   - state_e        : sequencer state encoding (also exported on the debug port)
//   - instr_class_e  : instruction class produced by mcycle_decode
//   - opcode / func constants of the supported MIPS subset
//   - pc_src, reg_dst and reg_src mux codes
package mcycle_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StHalt   = 3'd7
   } state_e;

   typedef enum logic [3:0] {
      ClsAluR,
      ClsJr,
      ClsAluI,
      ClsLw,
      ClsSw,
      ClsBeq,
      ClsBne,
      ClsJ,
      ClsJal,
      ClsIllegal
   } instr_class_e;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpJal   = 6'h03;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpBne   = 6'h05;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpAddiu = 6'h09;
   localparam logic [5:0] OpSlti  = 6'h0A;
   localparam logic [5:0] OpAndi  = 6'h0C;
   localparam logic [5:0] OpOri   = 6'h0D;
   localparam logic [5:0] OpLui   = 6'h0F;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;

   localparam logic [5:0] FuncJr  = 6'h08;

   localparam logic [1:0] PcSrcSeq    = 2'd0;  // PC + 4
   localparam logic [1:0] PcSrcBranch = 2'd1;
   localparam logic [1:0] PcSrcJump   = 2'd2;
   localparam logic [1:0] PcSrcRs     = 2'd3;

   localparam logic [1:0] RegDstRt = 2'd0;
   localparam logic [1:0] RegDstRd = 2'd1;
   localparam logic [1:0] RegDstRa = 2'd2;  // $31

   localparam logic [1:0] RegSrcAlu  = 2'd0;
   localparam logic [1:0] RegSrcMdr  = 2'd1;
   localparam logic [1:0] RegSrcLink = 2'd2;

endpackage

// File: rtl/mcycle_sequencer_if.sv
// mcycle_sequencer_if: shared memory port handshake between the sequencer and memory.
//   mem_req      : access request (sequencer -> memory)
//   mem_we       : write request, qualified by mem_req
//   mem_sel_data : address select, 0 = PC, 1 = ALU result
//   mem_ready    : memory accepted/returned this cycle (memory -> sequencer)
// Modports: master = sequencer side, slave = memory side.
interface mcycle_sequencer_if;

   logic mem_req;
   logic mem_we;
   logic mem_sel_data;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_sel_data,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_sel_data,
      output mem_ready
   );

endinterface

// File: rtl/mcycle_decode.sv
// mcycle_decode: combinational instruction classifier.
//   opcode  in  6  IR[31:26]
//   func    in  6  IR[5:0]
//   cls     out    instruction class
//   illegal out 1  opcode is not part of the supported subset
module mcycle_decode
   import mcycle_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   func,
   output instr_class_e cls,
   output logic         illegal
);

   always_comb begin
      cls = ClsIllegal;
      case (opcode)
         OpRtype: cls = (func == FuncJr) ? ClsJr : ClsAluR;
         OpAddi, OpAddiu, OpSlti, OpAndi, OpOri, OpLui: cls = ClsAluI;
         OpLw:    cls = ClsLw;
         OpSw:    cls = ClsSw;
         OpBeq:   cls = ClsBeq;
         OpBne:   cls = ClsBne;
         OpJ:     cls = ClsJ;
         OpJal:   cls = ClsJal;
         default: cls = ClsIllegal;
      endcase
      illegal = (cls == ClsIllegal);
   end

endmodule

// File: rtl/mcycle_sequencer.sv
// mcycle_sequencer: multi-cycle control sequencer for the MIPS-subset CPU.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, sharing one memory port
// between instruction fetch and data access.
// Ports:
//   clk, rst (synchronous, active-low)
//   run                : allow starting a new instruction
//   opcode, func, zero : IR fields and ALU zero flag
//   mem                : memory handshake (master side)
//   ir_we, mdr_we, pc_we, pc_src, reg_write, reg_dst, reg_src, alu_src : datapath controls
//   state              : current state (debug), illegal : sticky unsupported-opcode flag
// Build option MCYC_PERF_EN adds cycle_cnt and instret_cnt (32-bit, wrapping).
module mcycle_sequencer
   import mcycle_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       run,
   input  logic [5:0]                 opcode,
   input  logic [5:0]                 func,
   input  logic                       zero,
   mcycle_sequencer_if.master         mem,
   output logic                       ir_we,
   output logic                       mdr_we,
   output logic                       pc_we,
   output logic [1:0]                 pc_src,
   output logic                       reg_write,
   output logic [1:0]                 reg_dst,
   output logic [1:0]                 reg_src,
   output logic                       alu_src,
   output logic [2:0]                 state,
   output logic                       illegal
`ifdef MCYC_PERF_EN
   ,
   output logic [31:0]                cycle_cnt,
   output logic [31:0]                instret_cnt
`endif
);

   state_e       state_q, state_d;
   logic         illegal_q, illegal_d;
   state_e       next_st;
   instr_class_e cls;
   logic         dec_illegal;
   logic         req, req_we, req_sel_data;

   mcycle_decode u_decode (
      .opcode  (opcode),
      .func    (func),
      .cls     (cls),
      .illegal (dec_illegal)
   );

   // Destination after an instruction retires.
   assign next_st = run ? StFetch : StIdle;

   always_comb begin
      state_d      = state_q;
      illegal_d    = illegal_q;
      req          = 1'b0;
      req_we       = 1'b0;
      req_sel_data = 1'b0;
      ir_we        = 1'b0;
      mdr_we       = 1'b0;
      pc_we        = 1'b0;
      pc_src       = PcSrcSeq;
      reg_write    = 1'b0;
      reg_dst      = RegDstRt;
      reg_src      = RegSrcAlu;
      alu_src      = 1'b0;

      case (state_q)
         StIdle: begin
            if (run) state_d = StFetch;
         end
         StFetch: begin
            req = 1'b1;
            if (mem.mem_ready) begin
               ir_we   = 1'b1;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (dec_illegal) begin
               illegal_d = 1'b1;
               state_d   = StHalt;
            end else begin
               case (cls)
                  ClsJ: begin
                     pc_we   = 1'b1;
                     pc_src  = PcSrcJump;
                     state_d = next_st;
                  end
                  ClsJal: begin
                     pc_we     = 1'b1;
                     pc_src    = PcSrcJump;
                     reg_write = 1'b1;
                     reg_dst   = RegDstRa;
                     reg_src   = RegSrcLink;
                     state_d   = next_st;
                  end
                  ClsJr: begin
                     pc_we   = 1'b1;
                     pc_src  = PcSrcRs;
                     state_d = next_st;
                  end
                  default: state_d = StExec;
               endcase
            end
         end
         StExec: begin
            alu_src = (cls == ClsAluI) || (cls == ClsLw) || (cls == ClsSw);
            case (cls)
               ClsBeq: begin
                  pc_we   = 1'b1;
                  pc_src  = zero ? PcSrcBranch : PcSrcSeq;
                  state_d = next_st;
               end
               ClsBne: begin
                  pc_we   = 1'b1;
                  pc_src  = zero ? PcSrcSeq : PcSrcBranch;
                  state_d = next_st;
               end
               ClsLw, ClsSw:     state_d = StMem;
               ClsAluR, ClsAluI: state_d = StWb;
               default:          state_d = next_st;
            endcase
         end
         StMem: begin
            req          = 1'b1;
            req_sel_data = 1'b1;
            req_we       = (cls == ClsSw);
            alu_src      = 1'b1;
            if (mem.mem_ready) begin
               if (cls == ClsSw) begin
                  pc_we   = 1'b1;
                  state_d = next_st;
               end else if (cls == ClsLw) begin
                  mdr_we  = 1'b1;
                  state_d = StWb;
               end
            end
         end
         StWb: begin
            reg_write = 1'b1;
            pc_we     = 1'b1;
            case (cls)
               ClsAluR: reg_dst = RegDstRd;
               ClsLw:   reg_src = RegSrcMdr;
               default: reg_dst = RegDstRt;
            endcase
            state_d = next_st;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   assign mem.mem_req      = req;
   assign mem.mem_we       = req_we;
   assign mem.mem_sel_data = req_sel_data;
   assign state            = state_q;
   assign illegal          = illegal_q;

`ifdef MCYC_PERF_EN
   logic [31:0] cycle_cnt_q, instret_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cycle_cnt_q   <= 32'd0;
         instret_cnt_q <= 32'd0;
      end else begin
         if (state_q != StIdle && state_q != StHalt) cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (pc_we) instret_cnt_q <= instret_cnt_q + 32'd1;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_mcycle_sequencer.sv
// tb_mcycle_sequencer: randomized self-checking bench for mcycle_sequencer.
// Each instruction is expanded into the list of states it must visit (wait states included),
// and every cycle is checked against what that state and class must produce.
module tb_mcycle_sequencer;

   localparam int CAluR = 0;
   localparam int CJr   = 1;
   localparam int CAluI = 2;
   localparam int CLw   = 3;
   localparam int CSw   = 4;
   localparam int CBeq  = 5;
   localparam int CBne  = 6;
   localparam int CJ    = 7;
   localparam int CJal  = 8;
   localparam int CIll  = 9;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       run = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] func = '0;
   logic       zero = 1'b0;
   logic       ir_we, mdr_we, pc_we, reg_write, alu_src, illegal;
   logic [1:0] pc_src, reg_dst, reg_src;
   logic [2:0] state;
`ifdef MCYC_PERF_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit from_idle = 1'b1;

   mcycle_sequencer_if mem_if ();

   mcycle_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .opcode      (opcode),
      .func        (func),
      .zero        (zero),
      .mem         (mem_if),
      .ir_we       (ir_we),
      .mdr_we      (mdr_we),
      .pc_we       (pc_we),
      .pc_src      (pc_src),
      .reg_write   (reg_write),
      .reg_dst     (reg_dst),
      .reg_src     (reg_src),
      .alu_src     (alu_src),
      .state       (state),
      .illegal     (illegal)
`ifdef MCYC_PERF_EN
      ,
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00: return (fn == 6'h08) ? CJr : CAluR;
         6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return CAluI;
         6'h23: return CLw;
         6'h2B: return CSw;
         6'h04: return CBeq;
         6'h05: return CBne;
         6'h02: return CJ;
         6'h03: return CJal;
         default: return CIll;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      run = 1'($urandom_range(0, 1));
      mem_if.mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
      check("rst_pc_we", 32'(pc_we), 32'd0);
`ifdef MCYC_PERF_EN
      check("rst_cycle_cnt", cycle_cnt, 32'd0);
      check("rst_instret_cnt", instret_cnt, 32'd0);
`endif
      rst = 1'b1;
      from_idle = 1'b1;
   endtask

   // zmode: 0/1 holds zero at that value, 2 randomizes it every cycle.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                            input int mw, input bit rnext, input int zmode);
      int  q[$];
      int  c, st, n_instr;
      bit  last, rdy, wr;
      int  exp_src;
      logic [31:0] cyc0, ret0;
      c = classify(op, fn);
      if (from_idle) q.push_back(0);
      for (int i = 0; i <= fw; i++) q.push_back(1);
      q.push_back(2);
      if (!(c == CJ || c == CJal || c == CJr)) begin
         q.push_back(3);
         if (c == CLw || c == CSw) for (int i = 0; i <= mw; i++) q.push_back(4);
         if (c == CAluR || c == CAluI || c == CLw) q.push_back(5);
      end
      n_instr = q.size() - (from_idle ? 1 : 0);
      cyc0 = '0;
      ret0 = '0;
`ifdef MCYC_PERF_EN
      cyc0 = cycle_cnt;
      ret0 = instret_cnt;
`endif
      for (int k = 0; k < q.size(); k++) begin
         st   = q[k];
         last = (k == q.size() - 1);
         if (st == 1 || st == 4) begin
            if (last) rdy = 1'b1;
            else rdy = (q[k + 1] != st);
         end else begin
            rdy = 1'($urandom_range(0, 1));
         end
         rst = 1'b1;
         if (st == 0) run = 1'b1;
         else if (last) run = rnext;
         else run = 1'($urandom_range(0, 1));
         opcode = (st <= 1) ? 6'($urandom) : op;
         func   = (st <= 1) ? 6'($urandom) : fn;
         zero   = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
         mem_if.mem_ready = rdy;
         #3;
         check("state", 32'(state), 32'(st));
         check("mem_req", 32'(mem_if.mem_req), 32'(st == 1 || st == 4));
         check("mem_we", 32'(mem_if.mem_we), 32'(st == 4 && c == CSw));
         check("mem_sel_data", 32'(mem_if.mem_sel_data), 32'(st == 4));
         check("ir_we", 32'(ir_we), 32'(st == 1 && rdy));
         check("mdr_we", 32'(mdr_we), 32'(st == 4 && rdy && c == CLw));
         check("pc_we", 32'(pc_we), 32'(last));
         check("illegal", 32'(illegal), 32'd0);
         if (last) begin
            case (c)
               CBeq:      exp_src = zero ? 1 : 0;
               CBne:      exp_src = zero ? 0 : 1;
               CJ, CJal:  exp_src = 2;
               CJr:       exp_src = 3;
               default:   exp_src = 0;
            endcase
            check("pc_src", 32'(pc_src), 32'(exp_src));
         end
         wr = (st == 2 && c == CJal) || (st == 5);
         check("reg_write", 32'(reg_write), 32'(wr));
         if (wr) begin
            check("reg_dst", 32'(reg_dst), (c == CJal) ? 32'd2 : (c == CAluR) ? 32'd1 : 32'd0);
            check("reg_src", 32'(reg_src), (c == CJal) ? 32'd2 : (c == CLw) ? 32'd1 : 32'd0);
         end
         if (st == 3) check("alu_src", 32'(alu_src), 32'(c == CAluI || c == CLw || c == CSw));
         @(posedge clk); #1;
      end
      from_idle = !rnext;
`ifdef MCYC_PERF_EN
      check("cycle_cnt_delta", cycle_cnt - cyc0, 32'(n_instr));
      check("instret_delta", instret_cnt - ret0, 32'd1);
`else
      if (n_instr < 0) check("n_instr", 32'(n_instr), 32'd0);
`endif
   endtask

   task automatic run_illegal(input int fw);
      int  q[$];
      int  st;
      bit  rdy;
      logic [31:0] cyc0, ret0, cyc_h;
      if (from_idle) q.push_back(0);
      for (int i = 0; i <= fw; i++) q.push_back(1);
      q.push_back(2);
      for (int i = 0; i < 6; i++) q.push_back(7);
      cyc0 = '0;
      ret0 = '0;
      cyc_h = '0;
`ifdef MCYC_PERF_EN
      cyc0 = cycle_cnt;
      ret0 = instret_cnt;
`endif
      for (int k = 0; k < q.size(); k++) begin
         st  = q[k];
         rdy = (st == 1) ? (q[k + 1] != 1) : 1'($urandom_range(0, 1));
         run = 1'b1;
         opcode = (st <= 1) ? 6'($urandom) : 6'h3F;
         func   = 6'($urandom);
         zero   = 1'($urandom_range(0, 1));
         mem_if.mem_ready = rdy;
         #3;
`ifdef MCYC_PERF_EN
         if (st == 7 && q[k - 1] == 2) cyc_h = cycle_cnt;
`endif
         check("ill_state", 32'(state), 32'(st));
         check("ill_flag", 32'(illegal), 32'(st == 7));
         check("ill_mem_req", 32'(mem_if.mem_req), 32'(st == 1));
         check("ill_ir_we", 32'(ir_we), 32'(st == 1 && rdy));
         check("ill_pc_we", 32'(pc_we), 32'd0);
         check("ill_reg_write", 32'(reg_write), 32'd0);
         @(posedge clk); #1;
      end
`ifdef MCYC_PERF_EN
      check("ill_cycle_to_halt", cyc_h - cyc0, 32'(fw + 2));
      check("ill_cycle_frozen", cycle_cnt, cyc_h);
      check("ill_instret", instret_cnt, ret0);
`endif
   endtask

   logic [5:0] alu_i_ops [6] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F};

   initial begin
      logic [5:0] op, fn;
      int pick;
      mem_if.mem_ready = 1'b0;
      do_reset();

      // Reset while a data access is pending: IDLE, FETCH, DECODE, EXEC, then MEM stalled.
      run = 1'b1; opcode = 6'h23; func = 6'h00; mem_if.mem_ready = 1'b0;
      @(posedge clk); #1;
      mem_if.mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_if.mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      #3;
      check("mid_mem_state", 32'(state), 32'd4);
      check("mid_mem_req", 32'(mem_if.mem_req), 32'd1);
      @(posedge clk); #1;
      check("mid_mem_rst_state", 32'(state), 32'd0);
      check("mid_mem_rst_req", 32'(mem_if.mem_req), 32'd0);
      check("mid_mem_rst_illegal", 32'(illegal), 32'd0);
      do_reset();

      run_instr(6'h00, 6'h20, 0, 0, 1'b1, 2);  // ADD
      run_instr(6'h23, 6'h11, 2, 1, 1'b1, 2);  // LW with waits
      run_instr(6'h04, 6'h00, 0, 0, 1'b1, 1);  // BEQ taken
      run_instr(6'h05, 6'h00, 0, 0, 1'b1, 1);  // BNE not taken
      run_instr(6'h05, 6'h00, 0, 0, 1'b1, 0);  // BNE taken
      run_instr(6'h03, 6'h00, 0, 0, 1'b0, 2);  // JAL, run low at retire
      run_instr(6'h2B, 6'h00, 0, 3, 1'b1, 2);  // SW with waits

      for (int n = 0; n < 300; n++) begin
         pick = $urandom_range(0, 8);
         fn = 6'($urandom);
         case (pick)
            0: begin op = 6'h00; if (fn == 6'h08) fn = 6'h20; end
            1: begin op = 6'h00; fn = 6'h08; end
            2: op = alu_i_ops[$urandom_range(0, 5)];
            3: op = 6'h23;
            4: op = 6'h2B;
            5: op = 6'h04;
            6: op = 6'h05;
            7: op = 6'h02;
            default: op = 6'h03;
         endcase
         run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2),
                   ($urandom_range(0, 3) != 0), 2);
      end

      run_illegal(1);
      do_reset();
      run_instr(6'h00, 6'h25, 0, 0, 1'b0, 2);  // recovers after reset from HALT

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
